// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is split into STAGES
// register-separated segments, with a valid/ready handshake that stalls the whole pipe.
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    // Stage registers: operand A, conditioned operand B', partial sum, carry, valid.
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] bx_q [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic             c_q  [STAGES];
    logic             v_q  [STAGES];

    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] bx_in [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic             c_in  [STAGES];
    logic             v_in  [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic             c_nxt [STAGES];

    logic cout_q, ovf_q, zero_q, neg_q;
    logic stall;

    assign stall    = v_q[LAST] && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0] part;

        if (k == 0) begin : g_first
            assign a_in[k]  = a;
            assign bx_in[k] = sub ? ~b : b;
            assign s_in[k]  = '0;
            assign c_in[k]  = cin ^ sub;
            assign v_in[k]  = in_valid && in_ready;
        end else begin : g_next
            assign a_in[k]  = a_q[k-1];
            assign bx_in[k] = bx_q[k-1];
            assign s_in[k]  = s_q[k-1];
            assign c_in[k]  = c_q[k-1];
            assign v_in[k]  = v_q[k-1];
        end

        assign part = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                    + {1'b0, bx_in[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_in[k]};

        // Bits at and above this chunk are still zero in s_in, so OR-ing inserts the slice.
        assign s_nxt[k] = s_in[k] | (WIDTH'(part[CHUNK-1:0]) << (k * CHUNK));
        assign c_nxt[k] = part[CHUNK];
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its predecessor's pre-edge value, giving a true shift rather than a fall-through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data registers are cleared along with valid bits so the outputs
            // read as zero right after reset, not just "invalid".
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= 1'b0;
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
            end
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= v_in[k];
                a_q[k]  <= a_in[k];
                bx_q[k] <= bx_in[k];
                s_q[k]  <= s_nxt[k];
                c_q[k]  <= c_nxt[k];
            end
            cout_q <= c_nxt[LAST];
            ovf_q  <= (a_in[LAST][WIDTH-1] == bx_in[LAST][WIDTH-1])
                   && (s_nxt[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
            zero_q <= (s_nxt[LAST] == '0);
            neg_q  <= s_nxt[LAST][WIDTH-1];
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined adder/subtractor for the Hack-style ALU datapath.
- Generalises the single-bit full adder to a WIDTH-bit ripple chain, split into STAGES register-separated carry segments.
- Adds a subtract mode, carry/borrow in and out, status flags, and a valid/ready handshake with backpressure.
- Sits between operand fetch and the ALU result mux. Throughput is one operation per cycle.

Parameters:
WIDTH, 16, operand/result width in bits; must be >= 2
STAGES, 4, number of pipeline stages; 1 <= STAGES <= WIDTH and WIDTH % STAGES == 0; CHUNK = WIDTH/STAGES bits added per stage

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: A+B+cin; 1: A-B-cin
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  raw carry out of MSB (sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow
zero  output  1  sum == 0
neg  output  1  sum[WIDTH-1]

Behaviour:
- Arithmetic: B' = sub ? ~b : b; c0 = cin ^ sub; {cout, sum} = a + B' + c0.
- ovf = (a[MSB] == B'[MSB]) && (sum[MSB] != a[MSB]).
- Stage k (0..STAGES-1) computes bits [k*CHUNK +: CHUNK] from the registered carry of stage k-1 (stage 0 uses c0).
- Each stage register carries the following upper operand slices forward; lower result slices are carried forward unchanged.
- Each stage register has a valid bit v[k]. The output register is the last stage; out_valid = v[STAGES-1].
- sum, cout, ovf, zero and neg are registered in the last stage. No combinational path from inputs to these outputs.
- Stall: stall = out_valid && !out_ready. When stall = 1, every stage register and valid bit holds its value.
- in_ready = !stall. This is a combinational path from out_ready and is allowed.
- Accept: a beat is taken on an edge where in_valid && in_ready. a, b, cin and sub are sampled only then.
- Latency: a beat accepted at edge t presents out_valid=1 with its result after edge t+STAGES-1. With STAGES=1, the result is visible in the cycle after acceptance.
- Result hold: a result stays stable on all outputs until the edge where out_valid && out_ready.
- Bubbles propagate. When not stalled, v[k] <= v[k-1] and v[0] <= in_valid && in_ready.
- Ordering: results leave in acceptance order. No beat is dropped or duplicated.
- Simultaneous accept and drain in the same cycle is legal and gives full throughput.
- out_valid=1 with out_ready=1 and in_valid=0 drains the result; a bubble moves forward.
- Reset: on a clk edge with rst_n=0, all v[k] and data registers clear.
  - After that edge: out_valid=0, sum=0, cout=0, ovf=0, zero=0, neg=0, in_ready=1.
  - Beats in flight are discarded, including when reset lands mid-operation.
  - Inputs present during the reset edge are ignored.
- Outputs are don't-care-checked only while out_valid=1; data registers may hold stale values when out_valid=0.

Test Plan:
1. WIDTH=16, STAGES=4, out_ready=1: a=0x7FFF, b=0x0001, sub=0, cin=0 → exactly 4 edges later out_valid=1, sum=0x8000, cout=0, ovf=1, neg=1, zero=0.
2. Wrap-around: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, zero=1, ovf=0. Then a=0x0005, b=0x0005, sub=1 → sum=0x0000, cout=1, zero=1. Then a=0x0003, b=0x0005, sub=1, cin=1 → sum=0xFFFD, cout=0, neg=1.
3. Throughput: 8 back-to-back beats a=i, b=0x1000*i (i=0..7), in_valid held high, out_ready=1 → 8 consecutive out_valid cycles, in order, sum=0x1001*i.
4. Backpressure: stream 6 beats and drop out_ready for 3 cycles while out_valid=1 → in_ready=0 for those 3 cycles, output stable; on release the remaining results arrive in order with no loss or duplication.
5. Reset mid-operation: accept 3 beats, assert rst_n=0 for one edge after the 2nd beat's stage-1 edge → next cycle out_valid=0, all flags 0; no stale result appears afterwards; a new beat 0x0001+0x0001 yields 0x0002 after 4 edges.
6. Config sweep: rerun cases 1–3 with (WIDTH=16, STAGES=1) → latency 1; and (WIDTH=8, STAGES=8), where a=0x7F, b=0x01 → sum=0x80, ovf=1, latency 8.
